// File: rtl/sci_master_if.sv
`default_nettype none
// ============================================================================
// Module      : sci_master_if
// Description : Bundles the SCI master's user request/response handshake and
//               its serial peripheral lines. The master modport is the
//               controller's view and the slave modport is the user/peripheral
//               side.
// Revision    : 1.0 - initial release
// ============================================================================
interface sci_master_if #(
    parameter int NUM_PERIPHERALS = 8,
    parameter int ADDR_WIDTH      = 5,
    parameter int DATA_WIDTH      = 8
);
    localparam int SEL_WIDTH = (NUM_PERIPHERALS > 1) ? $clog2(NUM_PERIPHERALS) : 1;

    // User request channel
    logic                       REQ_VALID;
    logic                       REQ_READY;
    logic                       REQ_WNR;
    logic [SEL_WIDTH-1:0]       REQ_SEL;
    logic [ADDR_WIDTH-1:0]      REQ_ADDR;
    logic [DATA_WIDTH-1:0]      REQ_WDATA;

    // User response channel
    logic                       RSP_VALID;
    logic [DATA_WIDTH-1:0]      RSP_RDATA;
    logic                       RSP_ERROR;

    // Serial peripheral lines
    logic [NUM_PERIPHERALS-1:0] SCI_CSN;
    logic                       SCI_REQ;
    logic                       SCI_RESP;
    logic                       SCI_ACK;

    modport master (
        input  REQ_VALID, REQ_WNR, REQ_SEL, REQ_ADDR, REQ_WDATA,
        input  SCI_RESP, SCI_ACK,
        output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERROR,
        output SCI_CSN, SCI_REQ
    );

    modport slave (
        output REQ_VALID, REQ_WNR, REQ_SEL, REQ_ADDR, REQ_WDATA,
        output SCI_RESP, SCI_ACK,
        input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERROR,
        input  SCI_CSN, SCI_REQ
    );
endinterface
`default_nettype wire

// File: rtl/sci_master.sv
`default_nettype none
// ============================================================================
// Module      : sci_master
// Description : Serial control interface master. Accepts one register
//               read/write request at a time, shifts a command frame out on
//               SCI_REQ to the selected peripheral, waits for ACK (with a
//               timeout) and collects read data MSB-first from SCI_RESP.
// Revision    : 1.0 - initial release
// ============================================================================
module sci_master #(
    parameter int NUM_PERIPHERALS = 8,
    parameter int ADDR_WIDTH      = 5,
    parameter int DATA_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic         CLK,
    input  logic         RSTN,
    sci_master_if.master bus
);

    localparam int SEL_WIDTH = (NUM_PERIPHERALS > 1) ? $clog2(NUM_PERIPHERALS) : 1;
    localparam int FRAME_WR  = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int FRAME_RD  = 1 + ADDR_WIDTH;
    localparam int CNT_MAX   = (TIMEOUT_CYCLES > FRAME_WR) ? TIMEOUT_CYCLES : FRAME_WR;
    localparam int CNT_WIDTH = $clog2(CNT_MAX + 1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SEND     = 3'd1;
    localparam logic [2:0] ST_WAIT_ACK = 3'd2;
    localparam logic [2:0] ST_RECV     = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    logic [2:0]            state_q, state_d;
    logic                  ready_q, ready_d;
    logic                  wnr_q, wnr_d;
    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    logic [FRAME_WR-1:0]   shift_q, shift_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  sel_ok;
    logic                  csn_active;
    logic [CNT_WIDTH-1:0]  last_bit;
    logic [DATA_WIDTH-1:0] rx_next;
    logic [NUM_PERIPHERALS-1:0] csn_n;

    // Selects at or beyond the peripheral count have no chip select to drive
    assign sel_ok     = (32'(bus.REQ_SEL) < 32'(NUM_PERIPHERALS));
    assign csn_active = (state_q == ST_SEND) || (state_q == ST_WAIT_ACK) || (state_q == ST_RECV);
    // Reads stop after the address; writes carry the data byte too
    assign last_bit   = wnr_q ? CNT_WIDTH'(FRAME_WR - 1) : CNT_WIDTH'(FRAME_RD - 1);
    // Read data arrives MSB-first, so shift in at the LSB end
    assign rx_next    = DATA_WIDTH'({rx_q, bus.SCI_RESP});

    // Transaction sequencing: frame out, ACK wait, data in, one-cycle response
    always_comb begin
        state_d = state_q;
        wnr_d   = wnr_q;
        sel_d   = sel_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.REQ_VALID && ready_q) begin
                    wnr_d   = bus.REQ_WNR;
                    sel_d   = bus.REQ_SEL;
                    shift_d = {bus.REQ_WNR, bus.REQ_ADDR,
                               (bus.REQ_WNR ? bus.REQ_WDATA : {DATA_WIDTH{1'b0}})};
                    cnt_d   = '0;
                    rx_d    = '0;
                    if (sel_ok) begin
                        state_d = ST_SEND;
                    end else begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end
                end
            end
            ST_SEND: begin
                shift_d = {shift_q[FRAME_WR-2:0], 1'b0};
                if (cnt_q == last_bit) begin
                    state_d = ST_WAIT_ACK;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_WIDTH'(1);
                end
            end
            ST_WAIT_ACK: begin
                if (bus.SCI_ACK) begin
                    if (wnr_q) begin
                        state_d = ST_DONE;
                        err_d   = 1'b0;
                        rdata_d = '0;
                    end else begin
                        // The first ACK cycle of a read already carries the MSB
                        rx_d = rx_next;
                        if (DATA_WIDTH == 1) begin
                            state_d = ST_DONE;
                            err_d   = 1'b0;
                            rdata_d = rx_next;
                        end else begin
                            state_d = ST_RECV;
                            cnt_d   = CNT_WIDTH'(1);
                        end
                    end
                end else if (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_WIDTH'(1);
                end
            end
            ST_RECV: begin
                if (bus.SCI_ACK) begin
                    rx_d = rx_next;
                    if (cnt_q == CNT_WIDTH'(DATA_WIDTH - 1)) begin
                        state_d = ST_DONE;
                        err_d   = 1'b0;
                        rdata_d = rx_next;
                    end else begin
                        cnt_d   = cnt_q + CNT_WIDTH'(1);
                    end
                end else begin
                    // ACK dropped before the last data bit: partial data is discarded
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered so it stays low through reset and rises with IDLE entry
        ready_d = (state_d == ST_IDLE);
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
            wnr_q   <= 1'b0;
            sel_q   <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            wnr_q   <= wnr_d;
            sel_q   <= sel_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // One-hot active-low chip select for the captured peripheral while busy
    always_comb begin
        csn_n = '1;
        if (csn_active) begin
            for (int i = 0; i < NUM_PERIPHERALS; i++) begin
                if (sel_q == SEL_WIDTH'(i)) begin
                    csn_n[i] = 1'b0;
                end
            end
        end
    end

    assign bus.SCI_CSN   = csn_n;
    assign bus.SCI_REQ   = (state_q == ST_SEND) && shift_q[FRAME_WR-1];
    assign bus.REQ_READY = ready_q;
    assign bus.RSP_VALID = (state_q == ST_DONE);
    assign bus.RSP_RDATA = rdata_q;
    assign bus.RSP_ERROR = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sci_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_sci_master
// Description : Directed bench for sci_master with a behavioural register-file
//               peripheral on the SCI lines and a second instance with a
//               non-power-of-two peripheral count for out-of-range selects.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sci_master;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    sci_master_if #(.NUM_PERIPHERALS(8), .ADDR_WIDTH(5), .DATA_WIDTH(8)) bus ();
    sci_master_if #(.NUM_PERIPHERALS(5), .ADDR_WIDTH(5), .DATA_WIDTH(8)) bus5 ();

    sci_master #(.NUM_PERIPHERALS(8), .ADDR_WIDTH(5), .DATA_WIDTH(8), .TIMEOUT_CYCLES(64))
        u_dut (.CLK(clk), .RSTN(rstn), .bus(bus.master));

    sci_master #(.NUM_PERIPHERALS(5), .ADDR_WIDTH(5), .DATA_WIDTH(8), .TIMEOUT_CYCLES(8))
        u_dut5 (.CLK(clk), .RSTN(rstn), .bus(bus5.master));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural peripheral: collects the frame, ACKs after ack_delay
    // cycles. ack_mode 0 = normal, 1 = never ACK, 2 = drop ACK after 3 bits.
    // ------------------------------------------------------------------
    int         ack_mode;
    int         ack_delay;
    logic [7:0] regs [32];
    int         rs_phase = 0;
    int         rs_bits = 0;
    int         rs_len = 99;
    int         rs_wait = 0;
    int         rs_left = 0;
    logic [13:0] rs_frame = '0;
    logic [7:0]  rs_data = '0;

    always @(negedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 32; i++) regs[i] = 8'h00;
            regs[16] = 8'h5A;
        end
        if (!rstn || bus.SCI_CSN == 8'hFF) begin
            rs_phase = 0; rs_bits = 0; rs_len = 99; rs_frame = '0;
            bus.SCI_ACK = 1'b0; bus.SCI_RESP = 1'b0;
        end else begin
            case (rs_phase)
                0: begin
                    rs_frame = {rs_frame[12:0], bus.SCI_REQ};
                    rs_bits++;
                    if (rs_bits == 1) rs_len = bus.SCI_REQ ? 14 : 6;
                    if (rs_bits == rs_len) begin
                        rs_phase = 1;
                        rs_wait  = ack_delay;
                    end
                end
                1: begin
                    if (rs_wait > 0) begin
                        rs_wait--;
                    end else if (ack_mode != 1) begin
                        if (rs_len == 14) begin
                            regs[rs_frame[12:8]] = rs_frame[7:0];
                            bus.SCI_ACK = 1'b1;
                            rs_phase = 3;
                        end else begin
                            rs_data = regs[rs_frame[4:0]];
                            rs_left = (ack_mode == 2) ? 2 : 7;
                            bus.SCI_ACK  = 1'b1;
                            bus.SCI_RESP = rs_data[7];
                            rs_data  = {rs_data[6:0], 1'b0};
                            rs_phase = 2;
                        end
                    end
                end
                2: begin
                    if (rs_left > 0) begin
                        bus.SCI_ACK  = 1'b1;
                        bus.SCI_RESP = rs_data[7];
                        rs_data = {rs_data[6:0], 1'b0};
                        rs_left--;
                    end else begin
                        bus.SCI_ACK = 1'b0; bus.SCI_RESP = 1'b0;
                        rs_phase = 3;
                    end
                end
                default: begin
                    bus.SCI_ACK = 1'b0; bus.SCI_RESP = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic        wnr;
        logic [2:0]  sel;
        logic [4:0]  addr;
        logic [7:0]  wdata;
        int          mode;
        logic [13:0] exp_frame;
        logic [7:0]  exp_csn;
        int          exp_cyc;
        logic        exp_err;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(input logic wnr, input logic [2:0] sel, input logic [4:0] addr,
                                input logic [7:0] wdata, input int mode, input logic [13:0] frame,
                                input logic [7:0] csn, input int cyc, input logic err,
                                input logic [7:0] rdata);
        vec_t v;
        v.wnr = wnr; v.sel = sel; v.addr = addr; v.wdata = wdata; v.mode = mode;
        v.exp_frame = frame; v.exp_csn = csn; v.exp_cyc = cyc; v.exp_err = err;
        v.exp_rdata = rdata;
        return v;
    endfunction

    function automatic logic [13:0] frame_of(input logic wnr, input logic [4:0] addr,
                                             input logic [7:0] wdata);
        return wnr ? {1'b1, addr, wdata} : {8'h00, 1'b0, addr};
    endfunction

    // Issue one request (REQ_VALID held until the response) and check it
    task automatic run_vec(input string tag, input vec_t v);
        int n; int len; int pulses; int rsp_cyc;
        logic [13:0] fr; logic [7:0] csn1; logic [7:0] csn_done; logic [7:0] rd;
        logic er; logic rdy_bad;
        ack_mode = v.mode;
        n = 0;
        while (bus.REQ_READY !== 1'b1 && n < 100) begin
            @(negedge clk); n++;
        end
        chk({tag, "_ready_idle"}, 32'(bus.REQ_READY), 32'(1));
        bus.REQ_WNR = v.wnr; bus.REQ_SEL = v.sel; bus.REQ_ADDR = v.addr;
        bus.REQ_WDATA = v.wdata; bus.REQ_VALID = 1'b1;
        len = v.wnr ? 14 : 6;
        fr = '0; pulses = 0; rsp_cyc = -1; rdy_bad = 1'b0;
        csn1 = '0; csn_done = '0; rd = '0; er = 1'b0;
        for (int cyc = 1; cyc <= 150; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                // The request was captured; disturb the held fields
                bus.REQ_ADDR = ~v.addr; bus.REQ_WDATA = ~v.wdata; bus.REQ_SEL = ~v.sel;
                csn1 = bus.SCI_CSN;
            end
            if (cyc <= len) fr = {fr[12:0], bus.SCI_REQ};
            if (rsp_cyc < 0 && bus.REQ_READY) rdy_bad = 1'b1;
            if (bus.RSP_VALID) begin
                pulses++;
                if (rsp_cyc < 0) begin
                    rsp_cyc = cyc; rd = bus.RSP_RDATA; er = bus.RSP_ERROR;
                    csn_done = bus.SCI_CSN; bus.REQ_VALID = 1'b0;
                end
            end
            if (rsp_cyc > 0 && cyc == rsp_cyc + 4) break;
        end
        bus.REQ_VALID = 1'b0;
        chk({tag, "_frame"},    32'(fr),       32'(v.exp_frame));
        chk({tag, "_csn"},      32'(csn1),     32'(v.exp_csn));
        chk({tag, "_rsp_cyc"},  32'(rsp_cyc),  32'(v.exp_cyc));
        chk({tag, "_pulses"},   32'(pulses),   32'(1));
        chk({tag, "_rdata"},    32'(rd),       32'(v.exp_rdata));
        chk({tag, "_err"},      32'(er),       32'(v.exp_err));
        chk({tag, "_csn_done"}, 32'(csn_done), 32'(8'hFF));
        chk({tag, "_busy_rdy"}, 32'(rdy_bad),  32'(0));
        chk({tag, "_hold_rd"},  32'(bus.RSP_RDATA), 32'(v.exp_rdata));
        chk({tag, "_hold_er"},  32'(bus.RSP_ERROR), 32'(v.exp_err));
    endtask

    // Request on the 5-peripheral instance; out-of-range selects finish at once
    task automatic sel_test(input logic [2:0] sel, input logic [4:0] exp_csn, input int exp_cyc);
        int rsp_cyc; logic [4:0] csn1; logic er; logic [7:0] rd;
        string tag;
        tag = $sformatf("sel%0d", sel);
        chk({tag, "_ready"}, 32'(bus5.REQ_READY), 32'(1));
        bus5.REQ_WNR = 1'b0; bus5.REQ_SEL = sel; bus5.REQ_ADDR = 5'h01; bus5.REQ_VALID = 1'b1;
        rsp_cyc = -1; csn1 = '0; er = 1'b0; rd = 8'hEE;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                bus5.REQ_VALID = 1'b0;
                csn1 = bus5.SCI_CSN;
            end
            if (bus5.RSP_VALID) begin
                rsp_cyc = cyc; er = bus5.RSP_ERROR; rd = bus5.RSP_RDATA;
                break;
            end
        end
        chk({tag, "_csn"},     32'(csn1),    32'(exp_csn));
        chk({tag, "_rsp_cyc"}, 32'(rsp_cyc), 32'(exp_cyc));
        chk({tag, "_err"},     32'(er),      32'(1));
        chk({tag, "_rdata"},   32'(rd),      32'(0));
        @(negedge clk);
        chk({tag, "_idle_csn"}, 32'(bus5.SCI_CSN), 32'(5'h1F));
    endtask

    initial begin
        int pulses;
        bus.REQ_VALID = 1'b0; bus.REQ_WNR = 1'b0; bus.REQ_SEL = '0;
        bus.REQ_ADDR = '0; bus.REQ_WDATA = '0;
        bus5.REQ_VALID = 1'b0; bus5.REQ_WNR = 1'b0; bus5.REQ_SEL = '0;
        bus5.REQ_ADDR = '0; bus5.REQ_WDATA = '0;
        bus5.SCI_ACK = 1'b0; bus5.SCI_RESP = 1'b0;
        ack_mode = 0; ack_delay = 2;

        //                wnr   sel   addr   wdata  mode frame                 csn    cyc err   rdata
        vecs.push_back(mk(1'b0, 3'd2, 5'h10, 8'h00, 0, 14'b00000000_010000, 8'hFB, 17, 1'b0, 8'h5A));
        vecs.push_back(mk(1'b1, 3'd0, 5'h03, 8'hA5, 0, 14'b1_00011_10100101, 8'hFE, 18, 1'b0, 8'h00));
        vecs.push_back(mk(1'b1, 3'd7, 5'h1F, 8'hFF, 0, 14'b1_11111_11111111, 8'h7F, 18, 1'b0, 8'h00));
        vecs.push_back(mk(1'b0, 3'd7, 5'h1F, 8'h00, 0, 14'b00000000_011111, 8'h7F, 17, 1'b0, 8'hFF));
        vecs.push_back(mk(1'b0, 3'd1, 5'h10, 8'h00, 1, 14'b00000000_010000, 8'hFD, 71, 1'b1, 8'h00));
        vecs.push_back(mk(1'b0, 3'd0, 5'h03, 8'h00, 0, 14'b00000000_000011, 8'hFE, 17, 1'b0, 8'hA5));
        vecs.push_back(mk(1'b0, 3'd2, 5'h10, 8'h00, 2, 14'b00000000_010000, 8'hFB, 13, 1'b1, 8'h00));
        for (int i = 0; i <= 16; i++)
            vecs.push_back(mk(1'b1, 3'(i % 8), 5'(i), 8'(i), 0, frame_of(1'b1, 5'(i), 8'(i)),
                              ~(8'h01 << (i % 8)), 18, 1'b0, 8'h00));
        for (int i = 0; i <= 16; i++)
            vecs.push_back(mk(1'b0, 3'(i % 8), 5'(i), 8'hFF, 0, frame_of(1'b0, 5'(i), 8'hFF),
                              ~(8'h01 << (i % 8)), 17, 1'b0, 8'(i)));

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_csn",   32'(bus.SCI_CSN),   32'(8'hFF));
        chk("rst_req",   32'(bus.SCI_REQ),   32'(0));
        chk("rst_ready", 32'(bus.REQ_READY), 32'(0));
        chk("rst_valid", 32'(bus.RSP_VALID), 32'(0));
        chk("rst_rdata", 32'(bus.RSP_RDATA), 32'(0));
        chk("rst_err",   32'(bus.RSP_ERROR), 32'(0));
        rstn = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(bus.REQ_READY), 32'(1));

        foreach (vecs[i]) run_vec($sformatf("v%0d", i), vecs[i]);

        // Reset in the middle of a write frame
        ack_mode = 0;
        bus.REQ_WNR = 1'b1; bus.REQ_SEL = 3'd3; bus.REQ_ADDR = 5'h05;
        bus.REQ_WDATA = 8'h3C; bus.REQ_VALID = 1'b1;
        @(negedge clk);
        bus.REQ_VALID = 1'b0;
        chk("abort_csn_busy", 32'(bus.SCI_CSN), 32'(8'hF7));
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        chk("abort_csn",   32'(bus.SCI_CSN),   32'(8'hFF));
        chk("abort_req",   32'(bus.SCI_REQ),   32'(0));
        chk("abort_valid", 32'(bus.RSP_VALID), 32'(0));
        chk("abort_ready", 32'(bus.REQ_READY), 32'(0));
        rstn = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.RSP_VALID) pulses++;
        end
        chk("abort_no_rsp", 32'(pulses), 32'(0));
        run_vec("post_abort_wr", mk(1'b1, 3'd3, 5'h05, 8'h3C, 0, 14'b1_00101_00111100,
                                    8'hF7, 18, 1'b0, 8'h00));
        run_vec("post_abort_rd", mk(1'b0, 3'd3, 5'h05, 8'h00, 0, 14'b00000000_000101,
                                    8'hF7, 17, 1'b0, 8'h3C));

        // Select range on the 5-peripheral instance (timeout 8 -> 6+1+8)
        sel_test(3'd4, 5'b01111, 15);
        sel_test(3'd5, 5'b11111, 1);
        sel_test(3'd7, 5'b11111, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
